// File: rtl/actor_controller_pkg.sv
// Shared definitions for the tile-grid actor engine: direction encoding,
// controller state encoding and the screen coordinate width.
package actor_controller_pkg;

    // Beam / screen coordinates are 10-bit and wrap modulo 1024.
    localparam int SCR_W = 10;

    // Direction encoding shared by move_dir and dir.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Controller state: either resting on a tile or gliding toward the next.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_e;

endpackage

// File: rtl/actor_controller_sprite_window.sv
// Beam-vs-sprite window test. Compares the beam position against the sprite
// origin (modulo 1024, so a sprite partly off the left/top edge still wraps
// correctly) and registers the hit flag and the row/column inside the sprite.
module actor_controller_sprite_window
    import actor_controller_pkg::*;
#(
    parameter int SPR_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SCR_W-1:0]            hpos,
    input  logic [SCR_W-1:0]            vpos,
    input  logic [SCR_W-1:0]            pix_x,
    input  logic [SCR_W-1:0]            pix_y,
    output logic                        spr_active,
    output logic [$clog2(SPR_SIZE)-1:0] spr_row,
    output logic [$clog2(SPR_SIZE)-1:0] spr_col
);

    localparam int RC_W = $clog2(SPR_SIZE);
    localparam logic [SCR_W-1:0] SIZE_C = SCR_W'(SPR_SIZE);

    logic [SCR_W-1:0] dx_s;
    logic [SCR_W-1:0] dy_s;
    logic             spr_active_d, spr_active_q;
    logic [RC_W-1:0]  spr_row_d, spr_row_q;
    logic [RC_W-1:0]  spr_col_d, spr_col_q;

    // Offset of the beam from the sprite origin and the resulting window hit.
    always_comb begin
        dx_s         = hpos - pix_x;
        dy_s         = vpos - pix_y;
        spr_active_d = (dx_s < SIZE_C) && (dy_s < SIZE_C);
        spr_row_d    = dy_s[RC_W-1:0];
        spr_col_d    = dx_s[RC_W-1:0];
    end

    // Register the window outputs (one clock of latency to the bitmap ROM).
    always_ff @(posedge clk) begin
        if (reset) begin
            spr_active_q <= 1'b0;
            spr_row_q    <= {RC_W{1'b0}};
            spr_col_q    <= {RC_W{1'b0}};
        end else begin
            spr_active_q <= spr_active_d;
            spr_row_q    <= spr_row_d;
            spr_col_q    <= spr_col_d;
        end
    end

    assign spr_active = spr_active_q;
    assign spr_row    = spr_row_q;
    assign spr_col    = spr_col_q;

endmodule

// File: rtl/actor_controller.sv
// Tile-grid actor engine: tile position, facing direction, smooth sub-tile
// motion, animation timing and the sprite window for one actor.
// Optional build macro ACTOR_WRAP_TUNNEL_EN: horizontal moves off the left or
// right border wrap to the opposite border (tunnel) instead of being blocked.
module actor_controller
    import actor_controller_pkg::*;
#(
    parameter int COORD_W       = 5,
    parameter int TILE_SHIFT    = 3,
    parameter int BORDER_X_MIN  = 1,
    parameter int BORDER_X_MAX  = 28,
    parameter int BORDER_Y_MIN  = 1,
    parameter int BORDER_Y_MAX  = 28,
    parameter int ANIM_FRAMES   = 2,
    parameter int ANIM_PERIOD   = 18,
    parameter int STEP_PERIOD   = 2,
    parameter int SPR_SIZE      = 16,
    parameter int SCREEN_OFFSET = 20,
    localparam int AF_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1,
    localparam int RC_W = $clog2(SPR_SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [SCR_W-1:0]   hpos,
    input  logic [SCR_W-1:0]   vpos,
    input  logic               load,
    input  logic [COORD_W-1:0] start_x,
    input  logic [COORD_W-1:0] start_y,
    input  logic               move_req,
    input  logic [1:0]         move_dir,
    input  logic               wall_ahead,
    output logic [COORD_W-1:0] probe_x,
    output logic [COORD_W-1:0] probe_y,
    output logic               move_ack,
    output logic               blocked,
    output logic               busy,
    output logic [COORD_W-1:0] tile_x,
    output logic [COORD_W-1:0] tile_y,
    output logic [1:0]         dir,
    output logic [AF_W-1:0]    anim_frame,
    output logic               spr_active,
    output logic [RC_W-1:0]    spr_row,
    output logic [RC_W-1:0]    spr_col
);

    localparam int SC_W  = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam int AC_W  = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    // One extra bit so the sub-offset can express "a full tile travelled".
    localparam int SUB_W = TILE_SHIFT + 1;

    localparam logic [COORD_W-1:0] X_MIN      = COORD_W'(BORDER_X_MIN);
    localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(BORDER_X_MAX);
    localparam logic [COORD_W-1:0] Y_MIN      = COORD_W'(BORDER_Y_MIN);
    localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(BORDER_Y_MAX);
    localparam logic [COORD_W-1:0] ONE_C      = COORD_W'(1);
    localparam logic [SC_W-1:0]    STEP_LAST  = SC_W'(STEP_PERIOD - 1);
    localparam logic [AC_W-1:0]    ANIM_LAST  = AC_W'(ANIM_PERIOD - 1);
    localparam logic [AF_W-1:0]    FRAME_LAST = AF_W'(ANIM_FRAMES - 1);
    localparam logic [SUB_W-1:0]   SUB_FULL   = SUB_W'(1 << TILE_SHIFT);
    localparam logic [SCR_W-1:0]   OFFSET_C   = SCR_W'(SCREEN_OFFSET);

    state_e             state_d, state_q;
    logic [COORD_W-1:0] tile_x_d, tile_x_q;
    logic [COORD_W-1:0] tile_y_d, tile_y_q;
    logic [COORD_W-1:0] target_x_d, target_x_q;
    logic [COORD_W-1:0] target_y_d, target_y_q;
    logic [1:0]         dir_d, dir_q;
    logic [AF_W-1:0]    anim_frame_d, anim_frame_q;
    logic [AC_W-1:0]    anim_cnt_d, anim_cnt_q;
    logic [SC_W-1:0]    step_cnt_d, step_cnt_q;
    logic [SUB_W-1:0]   sub_d, sub_q;
    logic               move_ack_d, move_ack_q;
    logic               blocked_d, blocked_q;

    logic [COORD_W-1:0] probe_x_s;
    logic [COORD_W-1:0] probe_y_s;
    logic               probe_out_s;
    logic [SUB_W-1:0]   sub_next_s;
    logic [SCR_W-1:0]   pix_x_s;
    logic [SCR_W-1:0]   pix_y_s;
    logic [SCR_W-1:0]   sub_ext_s;

    // Neighbour tile in the requested direction and whether it leaves the border box.
    always_comb begin
        probe_x_s = tile_x_q;
        probe_y_s = tile_y_q;
        case (move_dir)
            DIR_UP:    probe_y_s = tile_y_q - ONE_C;
            DIR_DOWN:  probe_y_s = tile_y_q + ONE_C;
`ifdef ACTOR_WRAP_TUNNEL_EN
            DIR_LEFT: begin
                if (tile_x_q == X_MIN) begin
                    probe_x_s = X_MAX;
                end else begin
                    probe_x_s = tile_x_q - ONE_C;
                end
            end
            DIR_RIGHT: begin
                if (tile_x_q == X_MAX) begin
                    probe_x_s = X_MIN;
                end else begin
                    probe_x_s = tile_x_q + ONE_C;
                end
            end
`else
            DIR_LEFT:  probe_x_s = tile_x_q - ONE_C;
            DIR_RIGHT: probe_x_s = tile_x_q + ONE_C;
`endif
            default: begin
                probe_x_s = tile_x_q;
                probe_y_s = tile_y_q;
            end
        endcase
        probe_out_s = (probe_x_s < X_MIN) || (probe_x_s > X_MAX) ||
                      (probe_y_s < Y_MIN) || (probe_y_s > Y_MAX);
    end

    // Next-state logic: load overrides ce; IDLE evaluates requests, MOVING glides.
    always_comb begin
        state_d      = state_q;
        tile_x_d     = tile_x_q;
        tile_y_d     = tile_y_q;
        target_x_d   = target_x_q;
        target_y_d   = target_y_q;
        dir_d        = dir_q;
        anim_frame_d = anim_frame_q;
        anim_cnt_d   = anim_cnt_q;
        step_cnt_d   = step_cnt_q;
        sub_d        = sub_q;
        move_ack_d   = 1'b0;
        blocked_d    = 1'b0;
        sub_next_s   = sub_q + SUB_W'(1);

        if (load) begin
            tile_x_d   = start_x;
            tile_y_d   = start_y;
            state_d    = ST_IDLE;
            sub_d      = {SUB_W{1'b0}};
            step_cnt_d = {SC_W{1'b0}};
            anim_cnt_d = {AC_W{1'b0}};
        end else if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (move_req) begin
                        dir_d = move_dir;
                        if (probe_out_s || wall_ahead) begin
                            blocked_d = 1'b1;
                        end else begin
                            move_ack_d = 1'b1;
                            target_x_d = probe_x_s;
                            target_y_d = probe_y_s;
                            state_d    = ST_MOVING;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MOVING: begin
                    // Animation only runs while the actor is travelling.
                    if (anim_cnt_q == ANIM_LAST) begin
                        anim_cnt_d = {AC_W{1'b0}};
                        if (anim_frame_q == FRAME_LAST) begin
                            anim_frame_d = {AF_W{1'b0}};
                        end else begin
                            anim_frame_d = anim_frame_q + AF_W'(1);
                        end
                    end else begin
                        anim_cnt_d = anim_cnt_q + AC_W'(1);
                    end
                    // One pixel per STEP_PERIOD ticks; a full tile lands on the target.
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = {SC_W{1'b0}};
                        if (sub_next_s == SUB_FULL) begin
                            tile_x_d = target_x_q;
                            tile_y_d = target_y_q;
                            sub_d    = {SUB_W{1'b0}};
                            state_d  = ST_IDLE;
                        end else begin
                            sub_d = sub_next_s;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + SC_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tile_x_q     <= X_MIN;
            tile_y_q     <= Y_MIN;
            target_x_q   <= X_MIN;
            target_y_q   <= Y_MIN;
            dir_q        <= DIR_UP;
            anim_frame_q <= {AF_W{1'b0}};
            anim_cnt_q   <= {AC_W{1'b0}};
            step_cnt_q   <= {SC_W{1'b0}};
            sub_q        <= {SUB_W{1'b0}};
            move_ack_q   <= 1'b0;
            blocked_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tile_x_q     <= tile_x_d;
            tile_y_q     <= tile_y_d;
            target_x_q   <= target_x_d;
            target_y_q   <= target_y_d;
            dir_q        <= dir_d;
            anim_frame_q <= anim_frame_d;
            anim_cnt_q   <= anim_cnt_d;
            step_cnt_q   <= step_cnt_d;
            sub_q        <= sub_d;
            move_ack_q   <= move_ack_d;
            blocked_q    <= blocked_d;
        end
    end

    // Screen position of the sprite origin: tile origin nudged along dir by the sub-offset.
    always_comb begin
        sub_ext_s = SCR_W'(sub_q);
        pix_x_s   = (SCR_W'(tile_x_q) << TILE_SHIFT) - OFFSET_C;
        pix_y_s   = (SCR_W'(tile_y_q) << TILE_SHIFT) - OFFSET_C;
        case (dir_q)
            DIR_UP:    pix_y_s = pix_y_s - sub_ext_s;
            DIR_LEFT:  pix_x_s = pix_x_s - sub_ext_s;
            DIR_DOWN:  pix_y_s = pix_y_s + sub_ext_s;
            DIR_RIGHT: pix_x_s = pix_x_s + sub_ext_s;
            default: begin
                pix_x_s = pix_x_s;
                pix_y_s = pix_y_s;
            end
        endcase
    end

    actor_controller_sprite_window #(
        .SPR_SIZE (SPR_SIZE)
    ) u_window (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .pix_x      (pix_x_s),
        .pix_y      (pix_y_s),
        .spr_active (spr_active),
        .spr_row    (spr_row),
        .spr_col    (spr_col)
    );

    assign probe_x    = probe_x_s;
    assign probe_y    = probe_y_s;
    assign move_ack   = move_ack_q;
    assign blocked    = blocked_q;
    assign busy       = (state_q == ST_MOVING);
    assign tile_x     = tile_x_q;
    assign tile_y     = tile_y_q;
    assign dir        = dir_q;
    assign anim_frame = anim_frame_q;

endmodule

// File: tb/tb_actor_controller.sv
// Directed testbench for actor_controller: reset, load, moves, wall/border
// refusal, animation rollover, tunnel (when ACTOR_WRAP_TUNNEL_EN is defined),
// sprite window and mid-move reset/load abort.
module tb_actor_controller;

    logic       clk;
    logic       reset;
    logic       ce;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       load;
    logic [4:0] start_x;
    logic [4:0] start_y;
    logic       move_req;
    logic [1:0] move_dir;
    logic       wall_ahead;
    logic [4:0] probe_x;
    logic [4:0] probe_y;
    logic       move_ack;
    logic       blocked;
    logic       busy;
    logic [4:0] tile_x;
    logic [4:0] tile_y;
    logic [1:0] dir;
    logic [0:0] anim_frame;
    logic       spr_active;
    logic [3:0] spr_row;
    logic [3:0] spr_col;

    int n_asserts;
    int n_fail;

    actor_controller dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .hpos       (hpos),
        .vpos       (vpos),
        .load       (load),
        .start_x    (start_x),
        .start_y    (start_y),
        .move_req   (move_req),
        .move_dir   (move_dir),
        .wall_ahead (wall_ahead),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .move_ack   (move_ack),
        .blocked    (blocked),
        .busy       (busy),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .dir        (dir),
        .anim_frame (anim_frame),
        .spr_active (spr_active),
        .spr_row    (spr_row),
        .spr_col    (spr_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given ce; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic ce_v);
        ce = ce_v;
        @(posedge clk);
        #1;
        ce = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    task automatic do_load(input logic [4:0] x, input logic [4:0] y);
        load = 1'b1; start_x = x; start_y = y;
        cyc(1'b0);
        load = 1'b0;
    endtask

    task automatic request(input logic [1:0] d, input logic wall);
        move_req = 1'b1; move_dir = d; wall_ahead = wall;
        cyc(1'b1);
        move_req = 1'b0; wall_ahead = 1'b0;
    endtask

    initial begin
        n_asserts = 0; n_fail = 0;
        reset = 1'b1; ce = 1'b0; hpos = 10'd0; vpos = 10'd0;
        load = 1'b0; start_x = 5'd0; start_y = 5'd0;
        move_req = 1'b0; move_dir = 2'd0; wall_ahead = 1'b0;

        // Reset state
        cyc(1'b0); cyc(1'b0);
        chk("rst_tile_x", tile_x, 1);
        chk("rst_tile_y", tile_y, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dir", dir, 0);
        chk("rst_frame", anim_frame, 0);
        chk("rst_ack", move_ack, 0);
        chk("rst_blocked", blocked, 0);
        chk("rst_active", spr_active, 0);
        chk("rst_row", spr_row, 0);
        chk("rst_col", spr_col, 0);
        reset = 1'b0;

        // 1. Load (2,2): origin pixel (1020,1020)
        do_load(5'd2, 5'd2);
        chk("load_tile_x", tile_x, 2);
        chk("load_tile_y", tile_y, 2);
        chk("load_busy", busy, 0);
        chk("load_frame", anim_frame, 0);
        hpos = 10'd1020; vpos = 10'd1020;
        cyc(1'b0);
        chk("win_wrap_active", spr_active, 1);
        chk("win_wrap_row", spr_row, 0);
        chk("win_wrap_col", spr_col, 0);
        hpos = 10'd1022; vpos = 10'd1021;
        cyc(1'b0);
        chk("win_wrap_row1", spr_row, 1);
        chk("win_wrap_col2", spr_col, 2);

        // Probe is the neighbour in move_dir
        move_dir = 2'd3; #1;
        chk("probe_right_x", probe_x, 3);
        chk("probe_right_y", probe_y, 2);
        move_dir = 2'd0; #1;
        chk("probe_up_y", probe_y, 1);

        // move_req without ce does nothing
        move_req = 1'b1; move_dir = 2'd3;
        cyc(1'b0);
        chk("noce_ack", move_ack, 0);
        chk("noce_busy", busy, 0);
        move_req = 1'b0;

        // 2. Move right from (2,2)
        request(2'd3, 1'b0);
        chk("mv1_ack", move_ack, 1);
        chk("mv1_busy", busy, 1);
        chk("mv1_dir", dir, 3);
        move_req = 1'b1;                  // ignored while moving
        ticks(4);
        move_req = 1'b0;
        chk("mv1_ack_pulse", move_ack, 0);
        chk("mv1_ignored_blk", blocked, 0);
        // sub-offset now 2 px: origin x = 1022, y = 1020
        hpos = 10'd1023; vpos = 10'd1021;
        cyc(1'b0);
        chk("mv1_win_active", spr_active, 1);
        chk("mv1_win_col", spr_col, 1);
        chk("mv1_win_row", spr_row, 1);
        ticks(11);
        chk("mv1_t15_busy", busy, 1);
        chk("mv1_t15_tile_x", tile_x, 2);
        ticks(1);
        chk("mv1_done_busy", busy, 0);
        chk("mv1_done_tile_x", tile_x, 3);
        chk("mv1_done_tile_y", tile_y, 2);
        chk("mv1_done_frame", anim_frame, 0);

        // Second move: frame flips at cumulative tick 18
        request(2'd3, 1'b0);
        chk("mv2_ack", move_ack, 1);
        ticks(1);
        chk("mv2_t17_frame", anim_frame, 0);
        ticks(1);
        chk("mv2_t18_frame", anim_frame, 1);
        ticks(14);
        chk("mv2_done_tile_x", tile_x, 4);
        chk("mv2_done_busy", busy, 0);

        // 3. Wall ahead: refused, dir updated
        request(2'd0, 1'b1);
        chk("wall_blocked", blocked, 1);
        chk("wall_ack", move_ack, 0);
        chk("wall_dir", dir, 0);
        chk("wall_tile_y", tile_y, 2);
        chk("wall_busy", busy, 0);
        cyc(1'b0);
        chk("wall_blk_pulse", blocked, 0);

        // Bottom border refusal
        do_load(5'd5, 5'd28);
        request(2'd2, 1'b0);
        chk("border_y_blocked", blocked, 1);
        chk("border_y_tile", tile_y, 28);

        // 4. Left move at x = BORDER_X_MIN
        do_load(5'd1, 5'd5);
        move_dir = 2'd1; #1;
`ifdef ACTOR_WRAP_TUNNEL_EN
        chk("tun_probe_x", probe_x, 28);
        request(2'd1, 1'b0);
        chk("tun_ack", move_ack, 1);
        chk("tun_blocked", blocked, 0);
        ticks(16);
        chk("tun_tile_x", tile_x, 28);
        chk("tun_busy", busy, 0);
`else
        chk("tun_probe_x", probe_x, 0);
        request(2'd1, 1'b0);
        chk("tun_blocked", blocked, 1);
        chk("tun_ack", move_ack, 0);
        chk("tun_tile_x", tile_x, 1);
`endif

        // 5. Window at tile (5,5): origin (20,20)
        do_load(5'd5, 5'd5);
        chk("load_keeps_frame", anim_frame, 1);
        hpos = 10'd20; vpos = 10'd20;
        cyc(1'b0);
        chk("win_hit", spr_active, 1);
        chk("win_hit_row", spr_row, 0);
        chk("win_hit_col", spr_col, 0);
        hpos = 10'd35; vpos = 10'd35;
        cyc(1'b0);
        chk("win_corner", spr_active, 1);
        chk("win_corner_row", spr_row, 15);
        chk("win_corner_col", spr_col, 15);
        hpos = 10'd36; vpos = 10'd20;
        cyc(1'b0);
        chk("win_miss", spr_active, 0);

        // 6. Reset mid-move
        request(2'd3, 1'b0);
        chk("abort_ack", move_ack, 1);
        ticks(6);
        reset = 1'b1;
        cyc(1'b1);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_tile_x", tile_x, 1);
        chk("abort_tile_y", tile_y, 1);
        chk("abort_ack_low", move_ack, 0);
        chk("abort_blk_low", blocked, 0);
        chk("abort_frame", anim_frame, 0);

        // Load mid-move: tile = start, dir retained, sub-offset cleared
        do_load(5'd5, 5'd5);
        request(2'd3, 1'b0);
        chk("ldab_ack", move_ack, 1);
        ticks(6);
        load = 1'b1; start_x = 5'd7; start_y = 5'd9;
        cyc(1'b1);
        load = 1'b0;
        chk("ldab_busy", busy, 0);
        chk("ldab_tile_x", tile_x, 7);
        chk("ldab_tile_y", tile_y, 9);
        chk("ldab_dir", dir, 3);
        chk("ldab_ack_low", move_ack, 0);
        hpos = 10'd36; vpos = 10'd52;
        cyc(1'b0);
        chk("ldab_win_active", spr_active, 1);
        chk("ldab_win_col", spr_col, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
